// File: rtl/mini_src_pkg.sv
// Shared opcode, ALU-code, state and control-word definitions for the Mini SRC control path.
package mini_src_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110, OP_SHR  = 5'b00111, OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001, OP_ROR  = 5'b01010, OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111, OP_DIV  = 5'b10000, OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010, OP_BR   = 5'b10011, OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101, OP_IN   = 5'b10110, OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000, OP_MFLO = 5'b11001, OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = OP_ADD, ALU_AND = OP_AND, ALU_OR = OP_OR;
  localparam logic [4:0] ALU_INC = 5'b11111;

  typedef enum logic [3:0] {
    S_RESET = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
    S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd9
  } state_t;

  typedef struct packed {
    logic [4:0] alu;
    logic       run;
    logic Pout, MDROut, ZHIout, ZLOout, HIout, LOout, Cout, InPortout, Rout, BAout;
    logic Pen, MARen, MDRen, IRen, Yen, Zen, HIen, LOen, Rin, ConIn, OutPorten;
    logic Read, Write, Gra, Grb, Grc;
  } ctrl_word_t;

  // Final execute state of each instruction; T2 means the instruction has no execute phase.
  function automatic state_t last_state(input logic [4:0] op);
    case (op)
      OP_LD, OP_ST:                                   last_state = S_T7;
      OP_MUL, OP_DIV, OP_BR:                          last_state = S_T6;
      OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA,
      OP_SHL, OP_ROR, OP_ROL, OP_ADDI, OP_ANDI, OP_ORI: last_state = S_T5;
      OP_NEG, OP_NOT:                                 last_state = S_T4;
      OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO:         last_state = S_T3;
      OP_NOP, OP_JAL:                                 last_state = S_T2;
      default:                                        last_state = S_T2;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational control-word decode from {state, opcode, con_ff}; no storage.
module ctrl_out_decode
  import mini_src_pkg::*;
#(
  parameter bit RESET_PC_ST = 1'b0
) (
  input  state_t     i_state,
  input  logic [4:0] i_op,
  input  logic       i_con_ff,
  output ctrl_word_t o_cw
);

  always_comb begin
    o_cw     = '0;
    o_cw.run = 1'b1;
    case (i_state)
      S_RESET: o_cw.Pen = RESET_PC_ST;
      S_T0: begin o_cw.Pout = 1'b1; o_cw.MARen = 1'b1; o_cw.Zen = 1'b1; o_cw.alu = ALU_INC; end
      S_T1: begin o_cw.ZLOout = 1'b1; o_cw.Pen = 1'b1; o_cw.Read = 1'b1; o_cw.MDRen = 1'b1; end
      S_T2: begin o_cw.MDROut = 1'b1; o_cw.IRen = 1'b1; end
      S_HALT: o_cw.run = 1'b0;
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        case (i_op)
          OP_LD, OP_LDI, OP_ST: begin
            case (i_state)
              S_T3: begin o_cw.Grb = 1'b1; o_cw.BAout = 1'b1; o_cw.Yen = 1'b1; end
              S_T4: begin o_cw.Cout = 1'b1; o_cw.Zen = 1'b1; o_cw.alu = ALU_ADD; end
              S_T5: begin
                o_cw.ZLOout = 1'b1;
                if (i_op == OP_LDI) begin o_cw.Gra = 1'b1; o_cw.Rin = 1'b1; end
                else                o_cw.MARen = 1'b1;
              end
              S_T6: begin
                o_cw.MDRen = 1'b1;
                if (i_op == OP_LD) o_cw.Read = 1'b1;
                else if (i_op == OP_ST) begin o_cw.Gra = 1'b1; o_cw.Rout = 1'b1; end
              end
              S_T7: begin
                if (i_op == OP_LD) begin o_cw.MDROut = 1'b1; o_cw.Gra = 1'b1; o_cw.Rin = 1'b1; end
                else if (i_op == OP_ST) o_cw.Write = 1'b1;
              end
              default: ;
            endcase
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
          OP_MUL, OP_DIV: begin
            case (i_state)
              S_T3: begin o_cw.Grb = 1'b1; o_cw.Rout = 1'b1; o_cw.Yen = 1'b1; end
              S_T4: begin o_cw.Grc = 1'b1; o_cw.Rout = 1'b1; o_cw.Zen = 1'b1; o_cw.alu = i_op; end
              S_T5: begin
                o_cw.ZLOout = 1'b1;
                if (i_op == OP_MUL || i_op == OP_DIV) o_cw.LOen = 1'b1;
                else begin o_cw.Gra = 1'b1; o_cw.Rin = 1'b1; end
              end
              S_T6: if (i_op == OP_MUL || i_op == OP_DIV) begin o_cw.ZHIout = 1'b1; o_cw.HIen = 1'b1; end
              default: ;
            endcase
          end
          OP_ADDI, OP_ANDI, OP_ORI: begin
            case (i_state)
              S_T3: begin o_cw.Grb = 1'b1; o_cw.Rout = 1'b1; o_cw.Yen = 1'b1; end
              S_T4: begin
                o_cw.Cout = 1'b1; o_cw.Zen = 1'b1;
                o_cw.alu  = (i_op == OP_ADDI) ? ALU_ADD : (i_op == OP_ANDI) ? ALU_AND : ALU_OR;
              end
              S_T5: begin o_cw.ZLOout = 1'b1; o_cw.Gra = 1'b1; o_cw.Rin = 1'b1; end
              default: ;
            endcase
          end
          OP_NEG, OP_NOT: begin
            case (i_state)
              S_T3: begin o_cw.Grb = 1'b1; o_cw.Rout = 1'b1; o_cw.Zen = 1'b1; o_cw.alu = i_op; end
              S_T4: begin o_cw.ZLOout = 1'b1; o_cw.Gra = 1'b1; o_cw.Rin = 1'b1; end
              default: ;
            endcase
          end
          OP_BR: begin
            case (i_state)
              S_T3: begin o_cw.Gra = 1'b1; o_cw.Rout = 1'b1; o_cw.ConIn = 1'b1; end
              S_T4: begin o_cw.Pout = 1'b1; o_cw.Yen = 1'b1; end
              S_T5: begin o_cw.Cout = 1'b1; o_cw.Zen = 1'b1; o_cw.alu = ALU_ADD; end
              // The only output that follows con_ff combinationally: taken-branch PC load.
              S_T6: begin o_cw.ZLOout = 1'b1; o_cw.Pen = i_con_ff; end
              default: ;
            endcase
          end
          OP_JR:   if (i_state == S_T3) begin o_cw.Gra = 1'b1; o_cw.Rout = 1'b1; o_cw.Pen = 1'b1; end
          OP_IN:   if (i_state == S_T3) begin o_cw.InPortout = 1'b1; o_cw.Gra = 1'b1; o_cw.Rin = 1'b1; end
          OP_OUT:  if (i_state == S_T3) begin o_cw.Gra = 1'b1; o_cw.Rout = 1'b1; o_cw.OutPorten = 1'b1; end
          OP_MFHI: if (i_state == S_T3) begin o_cw.HIout = 1'b1; o_cw.Gra = 1'b1; o_cw.Rin = 1'b1; end
          OP_MFLO: if (i_state == S_T3) begin o_cw.LOout = 1'b1; o_cw.Gra = 1'b1; o_cw.Rin = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Mini SRC control sequencer: state register and next-state logic; outputs decoded from state.
module control_unit
  import mini_src_pkg::*;
#(
  parameter bit RESET_PC_ST = 1'b0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  output logic        run,
  output logic [3:0]  state,
  output logic [4:0]  alu_control,
  output logic        Pout, MDROut, ZHIout, ZLOout, HIout, LOout, Cout, InPortout, Rout, BAout,
  output logic        Pen, MARen, MDRen, IRen, Yen, Zen, HIen, LOen, Rin, ConIn, OutPorten,
  output logic        Read, Write,
  output logic        Gra, Grb, Grc
);

  state_t     r_state;
  ctrl_word_t w_cw;
  logic [4:0] w_op;
  logic       w_unused_ir;

  assign w_op        = ir[31:27];
  assign w_unused_ir = ^ir[26:0];

  // The T2 exit needs the opcode of the word being fetched, so ir must carry it by the end of T2.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_RESET;
    end else begin
      case (r_state)
        S_RESET: r_state <= S_T0;
        S_T0:    r_state <= S_T1;
        S_T1:    r_state <= S_T2;
        S_T2: begin
          if (w_op == OP_HALT)              r_state <= S_HALT;
          else if (last_state(w_op) == S_T2) r_state <= S_T0;
          else                               r_state <= S_T3;
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= (r_state >= last_state(w_op)) ? S_T0 : state_t'(r_state + 4'd1);
      endcase
    end
  end

  ctrl_out_decode #(.RESET_PC_ST(RESET_PC_ST)) u_dec (
    .i_state  (r_state),
    .i_op     (w_op),
    .i_con_ff (con_ff),
    .o_cw     (w_cw)
  );

  assign state       = r_state;
  assign run         = w_cw.run;
  assign alu_control = w_cw.alu;
  assign Pout = w_cw.Pout;   assign MDROut = w_cw.MDROut;     assign ZHIout = w_cw.ZHIout;
  assign ZLOout = w_cw.ZLOout; assign HIout = w_cw.HIout;     assign LOout = w_cw.LOout;
  assign Cout = w_cw.Cout;   assign InPortout = w_cw.InPortout; assign Rout = w_cw.Rout;
  assign BAout = w_cw.BAout;
  assign Pen = w_cw.Pen;     assign MARen = w_cw.MARen;       assign MDRen = w_cw.MDRen;
  assign IRen = w_cw.IRen;   assign Yen = w_cw.Yen;           assign Zen = w_cw.Zen;
  assign HIen = w_cw.HIen;   assign LOen = w_cw.LOen;         assign Rin = w_cw.Rin;
  assign ConIn = w_cw.ConIn; assign OutPorten = w_cw.OutPorten;
  assign Read = w_cw.Read;   assign Write = w_cw.Write;
  assign Gra = w_cw.Gra;     assign Grb = w_cw.Grb;           assign Grc = w_cw.Grc;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed test-plan cases then random instruction streams vs a step-list model.
module tb_control_unit;
  import mini_src_pkg::*;

  logic        clk = 1'b0, clr, con_ff;
  logic [31:0] ir;
  logic        run;
  logic [3:0]  state;
  logic [4:0]  alu_control;
  logic Pout, MDROut, ZHIout, ZLOout, HIout, LOout, Cout, InPortout, Rout, BAout;
  logic Pen, MARen, MDRen, IRen, Yen, Zen, HIen, LOen, Rin, ConIn, OutPorten;
  logic Read, Write, Gra, Grb, Grc;
  logic [25:0] obs;

  int n_tests = 0, n_fail = 0;

  control_unit dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .run(run), .state(state),
    .alu_control(alu_control),
    .Pout(Pout), .MDROut(MDROut), .ZHIout(ZHIout), .ZLOout(ZLOout), .HIout(HIout),
    .LOout(LOout), .Cout(Cout), .InPortout(InPortout), .Rout(Rout), .BAout(BAout),
    .Pen(Pen), .MARen(MARen), .MDRen(MDRen), .IRen(IRen), .Yen(Yen), .Zen(Zen),
    .HIen(HIen), .LOen(LOen), .Rin(Rin), .ConIn(ConIn), .OutPorten(OutPorten),
    .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc)
  );

  always #5 clk = ~clk;

  // Bits 9:0 are the bus drivers.
  assign obs = {Grc, Grb, Gra, Write, Read, OutPorten, ConIn, Rin, LOen, HIen, Zen, Yen, IRen,
                MDRen, MARen, Pen, BAout, Rout, InPortout, Cout, LOout, HIout, ZLOout, ZHIout,
                MDROut, Pout};

  localparam logic [25:0] M_POUT = 26'h1 << 0,  M_MDROUT = 26'h1 << 1,  M_ZHIOUT = 26'h1 << 2;
  localparam logic [25:0] M_ZLOOUT = 26'h1 << 3, M_HIOUT = 26'h1 << 4,  M_LOOUT = 26'h1 << 5;
  localparam logic [25:0] M_COUT = 26'h1 << 6,  M_INPOUT = 26'h1 << 7,  M_ROUT = 26'h1 << 8;
  localparam logic [25:0] M_BAOUT = 26'h1 << 9, M_PEN = 26'h1 << 10,    M_MAREN = 26'h1 << 11;
  localparam logic [25:0] M_MDREN = 26'h1 << 12, M_IREN = 26'h1 << 13,  M_YEN = 26'h1 << 14;
  localparam logic [25:0] M_ZEN = 26'h1 << 15,  M_HIEN = 26'h1 << 16,   M_LOEN = 26'h1 << 17;
  localparam logic [25:0] M_RIN = 26'h1 << 18,  M_CONIN = 26'h1 << 19,  M_OUTPEN = 26'h1 << 20;
  localparam logic [25:0] M_READ = 26'h1 << 21, M_WRITE = 26'h1 << 22,  M_GRA = 26'h1 << 23;
  localparam logic [25:0] M_GRB = 26'h1 << 24,  M_GRC = 26'h1 << 25;
  localparam logic [4:0]  A_ADD = 5'b00011, A_AND = 5'b00101, A_OR = 5'b00110, A_INC = 5'b11111;
  localparam state_t      TSEQ [8] = '{S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7};

  typedef struct packed { logic [25:0] m; logic [4:0] alu; } step_t;
  step_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_cycle(input string tag, input logic [3:0] st, input logic [25:0] m,
                           input logic [4:0] alu, input logic rn);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".ctrl"}, 32'(obs), 32'(m));
    chk({tag, ".alu"}, 32'(alu_control), 32'(alu));
    chk({tag, ".run"}, 32'(run), 32'(rn));
    chk({tag, ".bus1"}, 32'($countones(obs[9:0]) <= 1), 32'd1);
  endtask

  task automatic push(input logic [25:0] m, input logic [4:0] alu);
    exp_q.push_back('{m: m, alu: alu});
  endtask

  // Reference: the cycle-by-cycle step list of an instruction, fetch first.
  task automatic build(input logic [4:0] op, input logic c);
    exp_q.delete();
    push(M_POUT | M_MAREN | M_ZEN, A_INC);
    push(M_ZLOOUT | M_PEN | M_READ | M_MDREN, 5'd0);
    push(M_MDROUT | M_IREN, 5'd0);
    if (op <= 5'd2) begin
      push(M_GRB | M_BAOUT | M_YEN, 5'd0);
      push(M_COUT | M_ZEN, A_ADD);
      if (op == 5'd1) push(M_ZLOOUT | M_GRA | M_RIN, 5'd0);
      else begin
        push(M_ZLOOUT | M_MAREN, 5'd0);
        if (op == 5'd0) begin push(M_READ | M_MDREN, 5'd0); push(M_MDROUT | M_GRA | M_RIN, 5'd0); end
        else begin push(M_GRA | M_ROUT | M_MDREN, 5'd0); push(M_WRITE, 5'd0); end
      end
    end else if (op <= 5'd11 || op == 5'd15 || op == 5'd16) begin
      push(M_GRB | M_ROUT | M_YEN, 5'd0);
      push(M_GRC | M_ROUT | M_ZEN, op);
      if (op <= 5'd11) push(M_ZLOOUT | M_GRA | M_RIN, 5'd0);
      else begin push(M_ZLOOUT | M_LOEN, 5'd0); push(M_ZHIOUT | M_HIEN, 5'd0); end
    end else if (op >= 5'd12 && op <= 5'd14) begin
      push(M_GRB | M_ROUT | M_YEN, 5'd0);
      push(M_COUT | M_ZEN, (op == 5'd12) ? A_ADD : (op == 5'd13) ? A_AND : A_OR);
      push(M_ZLOOUT | M_GRA | M_RIN, 5'd0);
    end else if (op == 5'd17 || op == 5'd18) begin
      push(M_GRB | M_ROUT | M_ZEN, op);
      push(M_ZLOOUT | M_GRA | M_RIN, 5'd0);
    end else if (op == 5'd19) begin
      push(M_GRA | M_ROUT | M_CONIN, 5'd0);
      push(M_POUT | M_YEN, 5'd0);
      push(M_COUT | M_ZEN, A_ADD);
      push(M_ZLOOUT | (c ? M_PEN : 26'd0), 5'd0);
    end
    else if (op == 5'd20) push(M_GRA | M_ROUT | M_PEN, 5'd0);
    else if (op == 5'd22) push(M_INPOUT | M_GRA | M_RIN, 5'd0);
    else if (op == 5'd23) push(M_GRA | M_ROUT | M_OUTPEN, 5'd0);
    else if (op == 5'd24) push(M_HIOUT | M_GRA | M_RIN, 5'd0);
    else if (op == 5'd25) push(M_LOOUT | M_GRA | M_RIN, 5'd0);
  endtask

  // Entered one cycle before the instruction's T0; leaves with the DUT about to enter T0.
  task automatic run_instr(input logic [31:0] iv, input logic c, input int abort, input int halt_cyc);
    logic [4:0] op;
    bit rst;
    op  = iv[31:27];
    rst = 1'b0;
    build(op, c);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      chk_cycle($sformatf("op%0d.t%0d", op, i), TSEQ[i], exp_q[i].m, exp_q[i].alu, 1'b1);
      if (i == 0) begin ir = iv; con_ff = c; end
      if (i == abort) begin clr = 1'b1; rst = 1'b1; break; end
    end
    if (!rst && op == 5'd27) begin
      for (int k = 0; k < halt_cyc; k++) begin
        @(negedge clk);
        chk_cycle($sformatf("halt.c%0d", k), S_HALT, 26'd0, 5'd0, 1'b0);
      end
      clr = 1'b1;
      rst = 1'b1;
    end
    if (rst) begin
      @(negedge clk);
      chk_cycle($sformatf("rst.op%0d", op), 4'd0, 26'd0, 5'd0, 1'b1);
      clr = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] iv;
    int ab, hc;
    clr = 1'b1; ir = 32'h1A92_0000; con_ff = 1'b0;
    @(negedge clk);
    chk_cycle("reset", 4'd0, 26'd0, 5'd0, 1'b1);
    clr = 1'b0;

    run_instr(32'h1A92_0000, 1'b0, -1, 0);   // add R5,R2,R4
    run_instr(32'h0918_0095, 1'b0, -1, 0);   // ldi R2,0x95(R3)
    run_instr(32'h9800_0000, 1'b0, -1, 0);   // br, not taken
    run_instr(32'h9800_0000, 1'b1, -1, 0);   // br, taken
    run_instr(32'hD800_0000, 1'b0, -1, 20);  // halt, then clr
    run_instr(32'h1118_0010, 1'b0, 6, 0);    // st interrupted in T6
    run_instr(32'hD000_0000, 1'b0, -1, 0);   // nop

    for (int n = 0; n < 250; n++) begin
      iv = $urandom();
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1;
      hc = int'($urandom_range(1, 4));
      run_instr(iv, 1'($urandom_range(0, 1)), ab, hc);
    end

    @(negedge clk);
    chk("final.state", 32'(state), 32'(S_T0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
